// File: rtl/cpu_defs.sv
// Shared MIPS32 pipeline definitions: load-type encodings and the hardwired zero register.
// Imported by the writeback stage and by any forwarding logic that reuses load alignment.
package cpu_defs;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LW  = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment and sign/zero extension; purely combinational, no flow control.
// Undefined load types fall back to the full word.
module load_align
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  boff,
  input  logic [2:0]  ltype,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{boff, 3'b000} +: 8];
    // Halfword loads ignore boff[0]; misalignment is trapped upstream.
    half_sel = boff[1] ? rdata[31:16] : rdata[15:0];
    case (ltype)
      LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {24'd0, byte_sel};
      LT_LH:   data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_writeback.sv
// MEM/WB register and sole register-file write port; one cycle from capture to write.
// Aux (mul/div) writes fill idle slots; after AUX_MAX_WAIT unserved cycles one is forced and wb_stall_o holds the pipe.
module wb_writeback
  import cpu_defs::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int AUX_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic              mem_wreg_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              mem_is_load_i,
  input  logic [2:0]        mem_ltype_i,
  input  logic [1:0]        mem_boff_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              aux_req_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_data_i,
  output logic              aux_ack_o,
  output logic              wb_stall_o,
  output logic              writeEnable_o,
  output logic [ADDR_W-1:0] writeAddr_o,
  output logic [DATA_W-1:0] writeData_o
);

  localparam int CNT_W = $clog2(AUX_MAX_WAIT + 1);

  logic              valid;
  logic              wreg;
  logic              committed;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  wait_cnt;

  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] mem_data;
  logic              forced;
  logic              pending;
  logic              pipe_sel;
  logic              aux_sel;
  logic              hold;

  load_align u_align (
    .rdata (mem_rdata_i),
    .boff  (mem_boff_i),
    .ltype (mem_ltype_i),
    .data  (aligned)
  );

  assign mem_data = mem_is_load_i ? aligned : mem_result_i;

  always_comb begin
    forced   = rst && aux_req_i && (wait_cnt == CNT_W'(AUX_MAX_WAIT));
    pending  = rst && valid && wreg && (waddr != ADDR_W'(REG_ZERO)) && !committed;
    pipe_sel = pending && !forced;
    aux_sel  = rst && aux_req_i && !pipe_sel;
    hold     = stall_i || forced;

    wb_stall_o    = forced;
    aux_ack_o     = 1'b0;
    writeEnable_o = 1'b0;
    writeAddr_o   = '0;
    writeData_o   = '0;
    // An aux write to r0 still consumes its slot and is acked, but nothing is written.
    if (aux_sel) begin
      aux_ack_o = 1'b1;
      if (aux_addr_i != ADDR_W'(REG_ZERO)) begin
        writeEnable_o = 1'b1;
        writeAddr_o   = aux_addr_i;
        writeData_o   = aux_data_i;
      end
    end else if (pipe_sel) begin
      writeEnable_o = 1'b1;
      writeAddr_o   = waddr;
      writeData_o   = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid     <= 1'b0;
      wreg      <= 1'b0;
      committed <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      wait_cnt  <= '0;
    end else begin
      if (aux_req_i && !aux_ack_o) begin
        if (wait_cnt != CNT_W'(AUX_MAX_WAIT))
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      // committed keeps a held entry from being written twice.
      if (flush_i) begin
        valid <= 1'b0;
      end else if (hold) begin
        if (pipe_sel)
          committed <= 1'b1;
      end else begin
        valid     <= mem_valid_i;
        wreg      <= mem_wreg_i;
        waddr     <= mem_waddr_i;
        wdata     <= mem_data;
        committed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_writeback.sv
// Directed bench for wb_writeback with a rule-level reference model compared on every falling edge.
module tb_wb_writeback;
  import cpu_defs::*;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_wreg, mem_is_load, stall, flush, aux_req;
  logic [4:0]  mem_waddr, aux_addr;
  logic [31:0] mem_result, mem_rdata, aux_data;
  logic [2:0]  mem_ltype;
  logic [1:0]  mem_boff;
  logic        aux_ack, wb_stall, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_writeback #(.DATA_W(32), .ADDR_W(5), .AUX_MAX_WAIT(MAXW)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid_i   (mem_valid),
    .mem_wreg_i    (mem_wreg),
    .mem_waddr_i   (mem_waddr),
    .mem_result_i  (mem_result),
    .mem_is_load_i (mem_is_load),
    .mem_ltype_i   (mem_ltype),
    .mem_boff_i    (mem_boff),
    .mem_rdata_i   (mem_rdata),
    .stall_i       (stall),
    .flush_i       (flush),
    .aux_req_i     (aux_req),
    .aux_addr_i    (aux_addr),
    .aux_data_i    (aux_data),
    .aux_ack_o     (aux_ack),
    .wb_stall_o    (wb_stall),
    .writeEnable_o (we),
    .writeAddr_o   (waddr),
    .writeData_o   (wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference alignment by shifting and masking the word arithmetically.
  function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] lt);
    logic [31:0] b, h, sh;
    sh = 32'(off) * 8;
    b  = (w >> sh) & 32'hFF;
    sh = off[1] ? 32'd16 : 32'd0;
    h  = (w >> sh) & 32'hFFFF;
    case (lt)
      LT_LB:   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      LT_LBU:  return b;
      LT_LH:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      LT_LHU:  return h;
      default: return w;
    endcase
  endfunction

  // Model: the instruction sitting in WB, whether it was already written, and how long aux has waited.
  logic        m_valid = 1'b0, m_wreg = 1'b0, m_done = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_waited = 0;
  logic        e_we, e_ack, e_stall, d_pipe, fz, pd;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  always @(negedge clk) begin
    e_we = 0; e_ack = 0; e_stall = 0; d_pipe = 0; e_addr = '0; e_data = '0;
    if (rst) begin
      fz = aux_req && (m_waited >= MAXW);
      pd = m_valid && m_wreg && (m_addr != 5'd0) && !m_done;
      if (fz || (aux_req && !pd)) begin
        e_ack   = 1;
        e_stall = fz;
        if (aux_addr != 5'd0) begin
          e_we = 1; e_addr = aux_addr; e_data = aux_data;
        end
      end else if (pd) begin
        e_we = 1; e_addr = m_addr; e_data = m_data; d_pipe = 1;
      end
    end
    chk("model_we",    32'(we),       32'(e_we));
    chk("model_addr",  32'(waddr),    32'(e_addr));
    chk("model_data",  wdata,         e_data);
    chk("model_ack",   32'(aux_ack),  32'(e_ack));
    chk("model_stall", 32'(wb_stall), 32'(e_stall));
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_valid  <= 0;
      m_done   <= 0;
      m_waited <= 0;
    end else begin
      if (aux_req && !e_ack) m_waited <= (m_waited >= MAXW) ? MAXW : m_waited + 1;
      else                   m_waited <= 0;
      if (flush) begin
        m_valid <= 0;
      end else if (stall || e_stall) begin
        if (d_pipe) m_done <= 1;
      end else begin
        m_valid <= mem_valid;
        m_wreg  <= mem_wreg;
        m_addr  <= mem_waddr;
        m_data  <= mem_is_load ? ref_align(mem_rdata, mem_boff, mem_ltype) : mem_result;
        m_done  <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    mem_valid = 0; mem_wreg = 0; mem_waddr = '0; mem_result = '0; mem_is_load = 0;
    mem_ltype = LT_LW; mem_boff = '0; mem_rdata = '0; stall = 0; flush = 0;
  endtask

  task automatic set_mem(input logic [4:0] a, input logic [31:0] res, input logic ld,
                         input logic [2:0] t, input logic [1:0] o, input logic [31:0] rd);
    mem_valid = 1; mem_wreg = 1; mem_waddr = a; mem_result = res;
    mem_is_load = ld; mem_ltype = t; mem_boff = o; mem_rdata = rd;
  endtask

  logic [2:0]  ld_t[4]   = '{LT_LB, LT_LBU, LT_LH, LT_LW};
  logic [1:0]  ld_o[4]   = '{2'd3, 2'd3, 2'd2, 2'd0};
  logic [31:0] ld_exp[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA, 32'h80AA_BBCC};
  // Expected write addresses in cycles 1..9 of the forced-priority run (0 = no write).
  logic [4:0]  fa_norm[9]  = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd11, 5'd24, 5'd25, 5'd26, 5'd27};
  logic [4:0]  fa_flush[9] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd11, 5'd0,  5'd25, 5'd26, 5'd27};

  // mode 0: plain forced slot, 1: flush the deferred entry, 2: reset during the forced slot.
  task automatic forced_run(input int mode);
    int   nx;
    logic prev_stall;
    logic [4:0] ea;
    nx = 0;
    prev_stall = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0 && !prev_stall) nx++;
      set_mem(5'(20 + nx), 32'h100 + 32'(nx), 0, LT_LW, 2'd0, 32'd0);
      if (c == 1) begin aux_req = 1; aux_addr = 5'd11; aux_data = 32'h0000_0A11; end
      if (mode != 2 && c == 6) aux_req = 0;
      if (mode == 2 && c == 8) aux_req = 0;
      flush = (mode == 1 && c == 5);
      if (mode == 2 && c == 7) rst = 1;
      @(negedge clk);
      if (c == 5) begin
        chk("forced_ack",   32'(aux_ack),  32'd1);
        chk("forced_stall", 32'(wb_stall), 32'd1);
        chk("forced_addr",  32'(waddr),    32'd11);
      end
      if (mode < 2 && c >= 1) begin
        ea = (mode == 1) ? fa_flush[c-1] : fa_norm[c-1];
        chk("seq_we",   32'(we),    (ea != 5'd0) ? 32'd1 : 32'd0);
        chk("seq_addr", 32'(waddr), 32'(ea));
      end
      if (mode == 2 && c == 6) begin
        chk("rst_we",    32'(we),       32'd0);
        chk("rst_addr",  32'(waddr),    32'd0);
        chk("rst_data",  wdata,         32'd0);
        chk("rst_ack",   32'(aux_ack),  32'd0);
        chk("rst_stall", 32'(wb_stall), 32'd0);
      end
      if (mode == 2 && c == 7) begin
        chk("reack_ack",   32'(aux_ack),  32'd1);
        chk("reack_stall", 32'(wb_stall), 32'd0);
        chk("reack_addr",  32'(waddr),    32'd11);
      end
      prev_stall = wb_stall;
      if (mode == 2 && c == 5) begin
        #1 rst = 0;
      end
      tick();
    end
    clr_in();
    aux_req = 0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; aux_req = 0; aux_addr = '0; aux_data = '0;
    clr_in();
    repeat (3) tick();
    @(negedge clk);
    chk("reset_we",    32'(we),       32'd0);
    chk("reset_ack",   32'(aux_ack),  32'd0);
    chk("reset_stall", 32'(wb_stall), 32'd0);
    tick();
    rst = 1;
    repeat (2) tick();

    // Loads issued back to back; each is written the cycle after capture.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_mem(5'(i + 1), 32'hDEAD_0000, 1, ld_t[i], ld_o[i], 32'h80AA_BBCC);
      else       clr_in();
      @(negedge clk);
      if (i > 0) begin
        chk("load_we",   32'(we),    32'd1);
        chk("load_addr", 32'(waddr), 32'(i));
        chk("load_data", wdata,      ld_exp[i-1]);
      end
      tick();
    end
    repeat (2) tick();

    // Stalled entry is written once; aux fills the following stall cycle.
    set_mem(5'd5, 32'h0000_1234, 0, LT_LW, 2'd0, 32'd0);
    tick();
    clr_in();
    stall = 1;
    aux_req = 1; aux_addr = 5'd7; aux_data = 32'h0000_DEAD;
    @(negedge clk);
    chk("stall1_we",   32'(we),      32'd1);
    chk("stall1_addr", 32'(waddr),   32'd5);
    chk("stall1_data", wdata,        32'h0000_1234);
    chk("stall1_ack",  32'(aux_ack), 32'd0);
    tick();
    @(negedge clk);
    chk("stall2_addr", 32'(waddr),   32'd7);
    chk("stall2_data", wdata,        32'h0000_DEAD);
    chk("stall2_ack",  32'(aux_ack), 32'd1);
    tick();
    aux_req = 0;
    @(negedge clk);
    chk("stall3_we", 32'(we), 32'd0);
    tick();
    stall = 0;
    repeat (2) tick();

    // Pipeline write to r0 never reaches the port; aux takes the slot.
    set_mem(5'd0, 32'h0000_0055, 0, LT_LW, 2'd0, 32'd0);
    tick();
    clr_in();
    aux_req = 1; aux_addr = 5'd9; aux_data = 32'h0000_0099;
    @(negedge clk);
    chk("r0_we",   32'(we),      32'd1);
    chk("r0_addr", 32'(waddr),   32'd9);
    chk("r0_ack",  32'(aux_ack), 32'd1);
    tick();
    aux_addr = 5'd0; aux_data = 32'h0000_0077;
    @(negedge clk);
    chk("aux_r0_ack", 32'(aux_ack), 32'd1);
    chk("aux_r0_we",  32'(we),      32'd0);
    tick();
    aux_req = 0;
    repeat (2) tick();

    forced_run(0);
    forced_run(1);
    forced_run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
